// File: rtl/agc_pkg.sv
// Shared types and defaults for the AGC initiator/sequencer.
package agc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TICK,
        RUN,
        DRAIN,
        CAPTURE
    } agc_state_t;

    localparam int AGC_SQ_BITS     = 24;
    localparam int AGC_PR_BITS     = 21;
    localparam int AGC_LOG_PERIOD  = 17;
    localparam int SCALE_BITS      = 17;
    localparam int OFFSET_BITS     = 16;

    // Scale is fixed point with 12 fractional bits, so 4096 is a gain of one.
    localparam logic [SCALE_BITS-1:0] UNITY_SCALE = 17'd4096;

endpackage

// File: rtl/agc_controller_if.sv
// Controller <-> per-channel AGC core link: period timing, accumulator results, scale/offset loading.
interface agc_controller_if
    import agc_pkg::*;
#(
    parameter int SQ_BITS = AGC_SQ_BITS,
    parameter int PR_BITS = AGC_PR_BITS
);

    logic                   agc_tick;
    logic                   agc_ce;
    logic                   agc_rst;
    logic [SQ_BITS-1:0]     sq_accum;
    logic [PR_BITS-1:0]     gt_accum;
    logic [PR_BITS-1:0]     lt_accum;
    logic [SCALE_BITS-1:0]  agc_scale;
    logic [OFFSET_BITS-1:0] agc_offset;
    logic                   agc_scale_ce;
    logic                   agc_offset_ce;
    logic                   agc_apply;

    modport master (
        output agc_tick, agc_ce, agc_rst,
        output agc_scale, agc_offset, agc_scale_ce, agc_offset_ce, agc_apply,
        input  sq_accum, gt_accum, lt_accum
    );

    modport slave (
        input  agc_tick, agc_ce, agc_rst,
        input  agc_scale, agc_offset, agc_scale_ce, agc_offset_ce, agc_apply,
        output sq_accum, gt_accum, lt_accum
    );

endinterface

// File: rtl/agc_period_timer.sv
// Down-counter for the RUN (2^LOG_PERIOD enabled cycles) and DRAIN (ACC_LAT cycles) phases.
module agc_period_timer #(
    parameter int LOG_PERIOD = 17,
    parameter int ACC_LAT    = 3
) (
    input  logic clk_i,
    input  logic aresetn_i,
    input  logic load_i,
    output logic ce_o,
    output logic run_last_o,
    output logic drain_last_o
);

    localparam int CNT_W = LOG_PERIOD + 1;
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'((1 << LOG_PERIOD) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(ACC_LAT - 1);

    if (ACC_LAT < 1) begin : g_bad_acc_lat
        $error("agc_period_timer: ACC_LAT must be at least 1");
    end

    logic [CNT_W-1:0] cnt;
    logic             draining;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt      <= '0;
            ce_o     <= 1'b0;
            draining <= 1'b0;
        end else if (load_i) begin
            cnt      <= RUN_LOAD;
            ce_o     <= 1'b1;
            draining <= 1'b0;
        end else if (ce_o) begin
            if (cnt == '0) begin
                ce_o     <= 1'b0;
                draining <= 1'b1;
                cnt      <= DRAIN_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (draining) begin
            if (cnt == '0) begin
                draining <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign run_last_o   = ce_o && (cnt == '0);
    assign drain_last_o = draining && (cnt == '0);

endmodule

// File: rtl/agc_controller.sv
// AGC initiator: period sequencing, result capture with sticky done/overrun, scale/offset load and apply.
// Optional build macro AGC_PERIOD_COUNT_EN adds the period_cnt_o capture counter.
//
// state   | meaning
// IDLE    | waiting for start_i or en_i
// TICK    | one-cycle period start, cores clear accumulators
// RUN     | agc_ce high for 2^LOG_PERIOD cycles
// DRAIN   | ACC_LAT cycles for accumulator pipelines to settle
// CAPTURE | latch results, raise done, restart or go idle
module agc_controller
    import agc_pkg::*;
#(
    parameter int    SQ_BITS    = AGC_SQ_BITS,
    parameter int    PR_BITS    = AGC_PR_BITS,
    parameter int    LOG_PERIOD = AGC_LOG_PERIOD,
    parameter int    ACC_LAT    = 3,
    parameter string CLKTYPE    = "NONE"
) (
    input  logic                   clk_i,
    input  logic                   aresetn_i,
    input  logic                   en_i,
    input  logic                   start_i,
    input  logic                   lfsr_rst_i,
    agc_controller_if.master       core,
    output logic [SQ_BITS-1:0]     sq_o,
    output logic [PR_BITS-1:0]     gt_o,
    output logic [PR_BITS-1:0]     lt_o,
    output logic                   done_o,
    output logic                   overrun_o,
    input  logic                   done_ack_i,
    input  logic [SCALE_BITS-1:0]  scale_i,
    input  logic [OFFSET_BITS-1:0] offset_i,
    input  logic                   scale_wr_i,
    input  logic                   offset_wr_i,
    input  logic                   apply_req_i,
    output logic                   busy_o
`ifdef AGC_PERIOD_COUNT_EN
    ,
    output logic [15:0]            period_cnt_o
`endif
);

    if (CLKTYPE == "") begin : g_bad_clktype
        $error("agc_controller: CLKTYPE must name a clock domain");
    end

    agc_state_t state;
    logic       timer_ce;
    logic       run_last;
    logic       drain_last;
    logic       apply_pend;
    logic       wr_now;
    logic       apply_want;
    logic       apply_slot;
    logic       apply_fire;

    agc_period_timer #(
        .LOG_PERIOD (LOG_PERIOD),
        .ACC_LAT    (ACC_LAT)
    ) u_timer (
        .clk_i        (clk_i),
        .aresetn_i    (aresetn_i),
        .load_i       (state == TICK),
        .ce_o         (timer_ce),
        .run_last_o   (run_last),
        .drain_last_o (drain_last)
    );

    assign core.agc_ce = timer_ce;

    // Apply may only land on a cycle that is either idle or the start of the next
    // period, and never together with (or ahead of) a pending scale/offset load strobe.
    assign wr_now     = scale_wr_i | offset_wr_i;
    assign apply_want = apply_pend | apply_req_i;
    assign apply_slot = (state == IDLE) || ((state == CAPTURE) && en_i);
    assign apply_fire = apply_slot && apply_want && !wr_now;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state         <= IDLE;
            core.agc_tick <= 1'b0;
            busy_o        <= 1'b0;
            sq_o          <= '0;
            gt_o          <= '0;
            lt_o          <= '0;
            done_o        <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            core.agc_tick <= 1'b0;
            if (done_ack_i) begin
                done_o    <= 1'b0;
                overrun_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_i || en_i) begin
                        state         <= TICK;
                        core.agc_tick <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end
                TICK: begin
                    state <= RUN;
                end
                RUN: begin
                    if (run_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sq_o   <= core.sq_accum;
                    gt_o   <= core.gt_accum;
                    lt_o   <= core.lt_accum;
                    done_o <= 1'b1;
                    if (done_o && !done_ack_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (en_i) begin
                        state         <= TICK;
                        core.agc_tick <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            core.agc_scale     <= UNITY_SCALE;
            core.agc_offset    <= '0;
            core.agc_scale_ce  <= 1'b0;
            core.agc_offset_ce <= 1'b0;
            core.agc_apply     <= 1'b0;
            core.agc_rst       <= 1'b0;
            apply_pend         <= 1'b0;
        end else begin
            core.agc_scale_ce  <= scale_wr_i;
            core.agc_offset_ce <= offset_wr_i;
            if (scale_wr_i) begin
                core.agc_scale <= scale_i;
            end
            if (offset_wr_i) begin
                core.agc_offset <= offset_i;
            end
            core.agc_apply <= apply_fire;
            apply_pend     <= apply_want && !apply_fire;
            core.agc_rst   <= lfsr_rst_i;
        end
    end

`ifdef AGC_PERIOD_COUNT_EN
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            period_cnt_o <= '0;
        end else if (state == CAPTURE) begin
            period_cnt_o <= period_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_agc_controller.sv
// Directed bench for agc_controller with LOG_PERIOD=4, ACC_LAT=3 (21-cycle period incl. tick and capture).
module tb_agc_controller;

    logic        clk_i = 1'b0;
    logic        aresetn_i;
    logic        en_i, start_i, lfsr_rst_i;
    logic [23:0] sq_o;
    logic [20:0] gt_o, lt_o;
    logic        done_o, overrun_o, done_ack_i;
    logic [16:0] scale_i;
    logic [15:0] offset_i;
    logic        scale_wr_i, offset_wr_i, apply_req_i;
    logic        busy_o;
`ifdef AGC_PERIOD_COUNT_EN
    logic [15:0] period_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    agc_controller_if #(.SQ_BITS(24), .PR_BITS(21)) core_if ();

    agc_controller #(
        .SQ_BITS    (24),
        .PR_BITS    (21),
        .LOG_PERIOD (4),
        .ACC_LAT    (3),
        .CLKTYPE    ("NONE")
    ) dut (
        .clk_i        (clk_i),
        .aresetn_i    (aresetn_i),
        .en_i         (en_i),
        .start_i      (start_i),
        .lfsr_rst_i   (lfsr_rst_i),
        .core         (core_if),
        .sq_o         (sq_o),
        .gt_o         (gt_o),
        .lt_o         (lt_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o),
        .done_ack_i   (done_ack_i),
        .scale_i      (scale_i),
        .offset_i     (offset_i),
        .scale_wr_i   (scale_wr_i),
        .offset_wr_i  (offset_wr_i),
        .apply_req_i  (apply_req_i),
        .busy_o       (busy_o)
`ifdef AGC_PERIOD_COUNT_EN
        ,
        .period_cnt_o (period_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn_i   = 1'b0;
        en_i        = 1'b0;
        start_i     = 1'b0;
        lfsr_rst_i  = 1'b0;
        done_ack_i  = 1'b0;
        scale_i     = '0;
        offset_i    = '0;
        scale_wr_i  = 1'b0;
        offset_wr_i = 1'b0;
        apply_req_i = 1'b0;
        core_if.sq_accum = '0;
        core_if.gt_accum = '0;
        core_if.lt_accum = '0;

        // reset values
        #12;
        chk("rst_scale", 32'(core_if.agc_scale), 32'd4096);
        chk("rst_offset", 32'(core_if.agc_offset), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tick", 32'(core_if.agc_tick), 32'd0);
        chk("rst_ce", 32'(core_if.agc_ce), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_sq", 32'(sq_o), 32'd0);
        aresetn_i = 1'b1;
        step();
`ifdef AGC_PERIOD_COUNT_EN
        chk("rst_pcnt", 32'(period_cnt_o), 32'd0);
`endif

        // apply in IDLE without a write: next cycle, scale untouched
        apply_req_i = 1'b1;
        step();
        chk("idle_apply", 32'(core_if.agc_apply), 32'd1);
        chk("idle_apply_scale", 32'(core_if.agc_scale), 32'd4096);
        chk("idle_apply_sce", 32'(core_if.agc_scale_ce), 32'd0);
        apply_req_i = 1'b0;
        step();
        chk("idle_apply_once", 32'(core_if.agc_apply), 32'd0);

        // offset write with apply in same cycle: ce first, apply one cycle later
        offset_i = 16'h1234;
        offset_wr_i = 1'b1;
        apply_req_i = 1'b1;
        step();
        chk("ofs_ce", 32'(core_if.agc_offset_ce), 32'd1);
        chk("ofs_val", 32'(core_if.agc_offset), 32'h1234);
        chk("ofs_apply_defer", 32'(core_if.agc_apply), 32'd0);
        offset_wr_i = 1'b0;
        apply_req_i = 1'b0;
        step();
        chk("ofs_apply", 32'(core_if.agc_apply), 32'd1);
        chk("ofs_ce_pulse", 32'(core_if.agc_offset_ce), 32'd0);
        step();
        chk("ofs_apply_once", 32'(core_if.agc_apply), 32'd0);

        // LFSR resync passthrough
        lfsr_rst_i = 1'b1;
        step();
        chk("lfsr_rst", 32'(core_if.agc_rst), 32'd1);
        chk("lfsr_busy", 32'(busy_o), 32'd0);
        lfsr_rst_i = 1'b0;
        step();
        chk("lfsr_rst_off", 32'(core_if.agc_rst), 32'd0);

        // single-shot period
        core_if.sq_accum = 24'd16384;
        core_if.gt_accum = 21'd100;
        core_if.lt_accum = 21'd200;
        start_i = 1'b1;
        step();
        chk("ss_tick", 32'(core_if.agc_tick), 32'd1);
        chk("ss_tick_ce", 32'(core_if.agc_ce), 32'd0);
        chk("ss_busy", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        step();
        chk("ss_tick_len", 32'(core_if.agc_tick), 32'd0);
        n = 0;
        while (core_if.agc_ce === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("ss_ce_len", 32'(n), 32'd16);
        n = 0;
        while (done_o === 1'b0 && n < 40) begin
            n++;
            step();
        end
        chk("ss_gap", 32'(n), 32'd4);
        chk("ss_sq", 32'(sq_o), 32'd16384);
        chk("ss_gt", 32'(gt_o), 32'd100);
        chk("ss_lt", 32'(lt_o), 32'd200);
        chk("ss_done", 32'(done_o), 32'd1);
        chk("ss_busy_end", 32'(busy_o), 32'd0);
        chk("ss_overrun", 32'(overrun_o), 32'd0);
`ifdef AGC_PERIOD_COUNT_EN
        chk("ss_pcnt", 32'(period_cnt_o), 32'd1);
`endif
        done_ack_i = 1'b1;
        step();
        chk("ss_ack", 32'(done_o), 32'd0);
        done_ack_i = 1'b0;

        // free-run, three periods, no ack; en dropped during the third
        core_if.sq_accum = 24'd1;
        core_if.gt_accum = 21'd2;
        core_if.lt_accum = 21'd3;
        en_i = 1'b1;
        repeat (22) step();
        chk("fr1_done", 32'(done_o), 32'd1);
        chk("fr1_overrun", 32'(overrun_o), 32'd0);
        chk("fr1_sq", 32'(sq_o), 32'd1);
        chk("fr1_retick", 32'(core_if.agc_tick), 32'd1);
        core_if.sq_accum = 24'd4;
        core_if.gt_accum = 21'd5;
        core_if.lt_accum = 21'd6;
        repeat (21) step();
        chk("fr2_overrun", 32'(overrun_o), 32'd1);
        chk("fr2_lt", 32'(lt_o), 32'd6);
        core_if.sq_accum = 24'd7;
        repeat (5) step();
        en_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (15) step();
        chk("fr3_sq", 32'(sq_o), 32'd7);
        chk("fr3_busy", 32'(busy_o), 32'd0);
        chk("fr3_overrun", 32'(overrun_o), 32'd1);
        repeat (3) step();
        chk("fr3_no_restart", 32'(busy_o), 32'd0);
        done_ack_i = 1'b1;
        step();
        chk("fr_ack_done", 32'(done_o), 32'd0);
        chk("fr_ack_overrun", 32'(overrun_o), 32'd0);
        done_ack_i = 1'b0;

        // period A leaves done set
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (21) step();
        chk("pa_done", 32'(done_o), 32'd1);
        core_if.sq_accum = 24'h00ABCD;

        // period B: mid-RUN scale write + apply, ack in the capture cycle
        en_i = 1'b1;
        step();
        repeat (4) step();
        scale_i = 17'd8192;
        scale_wr_i = 1'b1;
        apply_req_i = 1'b1;
        step();
        chk("run_sce", 32'(core_if.agc_scale_ce), 32'd1);
        chk("run_scale", 32'(core_if.agc_scale), 32'd8192);
        chk("run_apply_early", 32'(core_if.agc_apply), 32'd0);
        scale_wr_i = 1'b0;
        apply_req_i = 1'b0;
        n = 0;
        repeat (15) begin
            step();
            if (core_if.agc_apply === 1'b1) n++;
        end
        chk("run_apply_held", 32'(n), 32'd0);
        chk("cap_busy", 32'(busy_o), 32'd1);
        chk("cap_ce", 32'(core_if.agc_ce), 32'd0);
        done_ack_i = 1'b1;
        step();
        chk("cap_ack_done", 32'(done_o), 32'd1);
        chk("cap_ack_overrun", 32'(overrun_o), 32'd0);
        chk("cap_sq", 32'(sq_o), 32'h00ABCD);
        chk("tick_apply_tick", 32'(core_if.agc_tick), 32'd1);
        chk("tick_apply", 32'(core_if.agc_apply), 32'd1);
        done_ack_i = 1'b0;
        en_i = 1'b0;
        step();
        chk("tick_apply_once", 32'(core_if.agc_apply), 32'd0);
        n = 0;
        repeat (20) begin
            step();
            if (core_if.agc_apply === 1'b1) n++;
        end
        chk("pc_no_apply", 32'(n), 32'd0);
        chk("pc_overrun", 32'(overrun_o), 32'd1);
        chk("pc_busy", 32'(busy_o), 32'd0);

        // asynchronous reset mid-RUN
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        chk("ar_pre_ce", 32'(core_if.agc_ce), 32'd1);
        aresetn_i = 1'b0;
        #1;
        chk("ar_ce", 32'(core_if.agc_ce), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_done", 32'(done_o), 32'd0);
        chk("ar_overrun", 32'(overrun_o), 32'd0);
        chk("ar_scale", 32'(core_if.agc_scale), 32'd4096);
        chk("ar_offset", 32'(core_if.agc_offset), 32'd0);
        chk("ar_sq", 32'(sq_o), 32'd0);
        #2;
        aresetn_i = 1'b1;
        n = 0;
        repeat (30) begin
            step();
            if (done_o !== 1'b0 || core_if.agc_ce !== 1'b0 || busy_o !== 1'b0) n++;
        end
        chk("ar_no_capture", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/agc_controller.md
Name: agc_controller

Overview:
- Initiator/sequencer for the per-channel AGC datapath cores.
- Generates the measurement-period timing (agc_tick, agc_ce) and the LFSR resync request.
- At period end, captures the square/probit accumulator results into a register-side holding bank with a sticky done/ack handshake.
- Loads software-supplied scale/offset into the cores and applies them only at a period boundary.

Parameters:
- SQ_BITS, 24, square accumulator width.
- PR_BITS, 21, probit accumulator width.
- LOG_PERIOD, 17, measurement period is 2^LOG_PERIOD clocks of agc_ce.
- ACC_LAT, 3, clocks from last agc_ce to accumulator outputs being final.
- CLKTYPE, "NONE", clock-domain attribute passed to timing constraints.

Ports:
- clk_i  in  1  single clock.
- aresetn_i  in  1  asynchronous, active-low reset.
- en_i  in  1  free-run: start a new period automatically after each capture.
- start_i  in  1  single-shot period request pulse, honoured in IDLE.
- lfsr_rst_i  in  1  software LFSR resync request.
- agc_tick_o  out  1  period start pulse; cores reset their accumulators.
- agc_ce_o  out  1  accumulate enable.
- agc_rst_o  out  1  LFSR reset to cores.
- sq_accum_i  in  SQ_BITS  square accumulator from core.
- gt_accum_i, lt_accum_i  in  PR_BITS each  probit accumulators from core.
- sq_o  out  SQ_BITS  captured square result.
- gt_o, lt_o  out  PR_BITS each  captured probit results.
- done_o  out  1  sticky: capture available.
- overrun_o  out  1  sticky: capture occurred while done_o was already set.
- done_ack_i  in  1  clears done_o and overrun_o.
- scale_i  in  17  new scale.
- offset_i  in  16  new offset.
- scale_wr_i, offset_wr_i  in  1  write strobes.
- apply_req_i  in  1  request apply of loaded scale/offset.
- agc_scale_o  out  17  scale to cores.
- agc_offset_o  out  16  offset to cores.
- agc_scale_ce_o, agc_offset_ce_o  out  1  load strobes.
- agc_apply_o  out  1  apply strobe.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; agc_scale_o = 17'h01000 (unity, 4096); agc_offset_o = 0; FSM in IDLE; apply pending flag cleared.
- All outputs are registered.
- FSM states: IDLE, TICK, RUN, DRAIN, CAPTURE.
- IDLE -> TICK when start_i or en_i is high.
- TICK: one cycle, agc_tick_o = 1, agc_ce_o = 0.
- RUN: agc_ce_o = 1 for exactly 2^LOG_PERIOD consecutive cycles, counted by a LOG_PERIOD+1 bit counter. No wrap or early exit.
- DRAIN: agc_ce_o = 0 for ACC_LAT cycles.
- CAPTURE: one cycle.
  - Latch sq/gt/lt inputs into the output registers.
  - Set done_o.
  - If done_o was already set and done_ack_i is low that cycle, also set overrun_o.
  - Then go to TICK if en_i is high, else IDLE.
- Done handshake: done_ack_i clears done_o and overrun_o. Set in the same cycle as an ack wins.
- start_i is ignored outside IDLE; it is not queued.
- Dropping en_i mid-period finishes the current period and then returns to IDLE.
- Scale/offset writes:
  - scale_wr_i registers scale_i into agc_scale_o and pulses agc_scale_ce_o on the following cycle. Offset behaves the same way.
  - Writes are accepted in any state.
- Apply:
  - apply_req_i sets a pending flag.
  - If busy_o is high, agc_apply_o pulses coincident with the next agc_tick_o.
  - If in IDLE, agc_apply_o pulses on the next cycle.
  - agc_apply_o never pulses in the same cycle as a scale or offset ce strobe, nor before the ce strobe of a write issued in the same cycle. In that case it is deferred one cycle; in TICK it is deferred to the following tick.
  - The pending flag clears when agc_apply_o fires.
- LFSR resync: agc_rst_o is a one-cycle-registered copy of lfsr_rst_i. It does not affect the FSM.
- Asynchronous reset mid-period: abort immediately to IDLE; no capture; done_o cleared.

Optional Feature:
- Macro: AGC_PERIOD_COUNT_EN.
- Defined: adds output period_cnt_o [15:0], which increments on each CAPTURE, wraps from 65535 to 0, and resets to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Package agc_pkg holds:
  - the FSM state enum;
  - the unity scale constant (4096);
  - default widths SQ_BITS, PR_BITS and LOG_PERIOD.
- One sub-module, agc_period_timer: the RUN/DRAIN counter, producing ce and last-cycle flags.

Test Plan (LOG_PERIOD=4, ACC_LAT=3):
- start_i pulse with en_i=0:
  - expected: tick 1 cycle, then ce high exactly 16 cycles, 3 idle cycles, then capture.
  - with sq_accum_i=16384, gt_accum_i=100, lt_accum_i=200: sq_o=16384, gt_o=100, lt_o=200, done_o=1, busy_o=0.
- en_i=1 held for 3 periods without ack: expect overrun_o=1 after the 2nd capture. Then done_ack_i clears both flags.
- done_ack_i in the capture cycle: done_o stays 1.
- scale_wr_i with scale_i=8192 and apply_req_i in the same cycle, mid-RUN:
  - agc_scale_ce_o on the next cycle;
  - agc_apply_o only with the next agc_tick_o.
- apply_req_i in IDLE with no prior write: agc_apply_o on the next cycle; agc_scale_o remains 4096.
- aresetn_i asserted mid-RUN: all outputs return to reset values immediately; no capture occurs afterward.
